// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared iterative mult/div unit: latch, launch, stall, single writeback.
// Optional watchdog on the BUSY wait is enabled by defining MULTDIV_WATCHDOG_EN.
module multdiv_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STATUS_REG  = 30,
  parameter int EXC_MULT    = 4,
  parameter int EXC_DIV     = 5,
  parameter int EXC_TIMEOUT = 6,
  parameter int TIMEOUT     = 40
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  md_valid,
  input  logic                  md_is_div,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [DATA_WIDTH-1:0] md_a,
  input  logic [DATA_WIDTH-1:0] md_b,
  output logic                  unit_start,
  output logic                  unit_is_div,
  output logic [DATA_WIDTH-1:0] unit_a,
  output logic [DATA_WIDTH-1:0] unit_b,
  input  logic                  unit_ready,
  input  logic [DATA_WIDTH-1:0] unit_result,
  input  logic                  unit_exception,
  output logic                  stall,
  output logic                  busy,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic [DATA_WIDTH-1:0] wb_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_is_div;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_exc;
  logic                  r_timeout;
  logic                  w_expire;
  logic                  w_finish;

`ifdef MULTDIV_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;

  // Count holds the number of completed BUSY cycles; this is the TIMEOUT-th one.
  assign w_expire = (r_state == S_BUSY) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == S_START) begin
      r_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  // Constant-false expiry; BUSY only leaves on unit_ready.
  assign w_expire = (TIMEOUT < 0);
`endif

  assign w_finish = (r_state == S_BUSY) && (unit_ready || w_expire);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (md_valid) w_state_next = S_START;
      S_START: w_state_next = S_BUSY;
      S_BUSY:  if (unit_ready || w_expire) w_state_next = S_WB;
      S_WB:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_is_div  <= 1'b0;
      r_rd      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_exc     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && md_valid) begin
        r_is_div  <= md_is_div;
        r_rd      <= md_rd;
        r_a       <= md_a;
        r_b       <= md_b;
        r_exc     <= 1'b0;
        r_timeout <= 1'b0;
      end
      // A ready arriving together with expiry wins, so timeout needs !unit_ready.
      if (w_finish) begin
        r_result  <= unit_result;
        r_exc     <= unit_ready & unit_exception;
        r_timeout <= ~unit_ready;
      end
    end
  end

  assign unit_start  = (r_state == S_START);
  assign unit_is_div = r_is_div;
  assign unit_a      = r_a;
  assign unit_b      = r_b;
  assign busy        = (r_state != S_IDLE);
  assign stall       = ((r_state == S_IDLE) && md_valid) || (r_state == S_START) ||
                       (r_state == S_BUSY);

  always_comb begin
    wb_en   = 1'b0;
    wb_reg  = '0;
    wb_data = '0;
    if (r_state == S_WB) begin
      if (r_timeout) begin
        wb_en   = 1'b1;
        wb_reg  = REG_ADDR_W'(STATUS_REG);
        wb_data = DATA_WIDTH'(EXC_TIMEOUT);
      end else if (r_exc) begin
        wb_en   = 1'b1;
        wb_reg  = REG_ADDR_W'(STATUS_REG);
        wb_data = r_is_div ? DATA_WIDTH'(EXC_DIV) : DATA_WIDTH'(EXC_MULT);
      end else if (r_rd != '0) begin
        wb_en   = 1'b1;
        wb_reg  = r_rd;
        wb_data = r_result;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed plus randomized bench for multdiv_ctrl with a register-file reference model.
// Define MULTDIV_WATCHDOG_EN for both files to exercise the watchdog build.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        md_valid;
  logic        md_is_div;
  logic [4:0]  md_rd;
  logic [31:0] md_a, md_b;
  logic        unit_start, unit_is_div;
  logic [31:0] unit_a, unit_b;
  logic        unit_ready;
  logic [31:0] unit_result;
  logic        unit_exception;
  logic        stall, busy, wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rf [32];
  logic [31:0] dut_rf [32];

  multdiv_ctrl dut (
    .clock(clock), .reset(reset),
    .md_valid(md_valid), .md_is_div(md_is_div), .md_rd(md_rd), .md_a(md_a), .md_b(md_b),
    .unit_start(unit_start), .unit_is_div(unit_is_div), .unit_a(unit_a), .unit_b(unit_b),
    .unit_ready(unit_ready), .unit_result(unit_result), .unit_exception(unit_exception),
    .stall(stall), .busy(busy), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  // Shadow register file built only from what the DUT actually writes back.
  always @(negedge clock) begin
    if (wb_en) dut_rf[wb_reg] <= wb_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference unit behaviour: plain arithmetic result for the op.
  function automatic logic [31:0] unit_model(input bit is_div, input logic [31:0] a, b);
    if (is_div) return (b == 0) ? 32'd0 : a / b;
    return a * b;
  endfunction

  // One full op: cycle 0 = md_valid in IDLE, cycle 1 = START, ready `delay` cycles after
  // START, then the WB cycle. Expectations come from the writeback rules, not the FSM.
  task automatic run_op(input bit is_div, input logic [4:0] rd, input logic [31:0] a, b,
                        input bit exc, input int delay, input bit valid_in_wb);
    logic [31:0] res;
    bit          e_en;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    res = unit_model(is_div, a, b);

    @(posedge clock); #1;
    md_valid = 1'b1; md_is_div = is_div; md_rd = rd; md_a = a; md_b = b;
    unit_ready = 1'b0; unit_exception = 1'b0;
    @(negedge clock);
    check("c0_stall", stall, 1); check("c0_busy", busy, 0);
    check("c0_start", unit_start, 0); check("c0_wb_en", wb_en, 0);

    // START: scramble the md_* inputs and offer a bogus ready that must be ignored.
    @(posedge clock); #1;
    md_valid = 1'b0; md_is_div = 1'($urandom); md_rd = 5'($urandom);
    md_a = $urandom; md_b = $urandom;
    unit_ready = 1'b1; unit_result = 32'hdead_beef; unit_exception = 1'b1;
    @(negedge clock);
    check("start_pulse", unit_start, 1); check("start_stall", stall, 1);
    check("start_busy", busy, 1); check("unit_a", unit_a, a);
    check("unit_b", unit_b, b); check("unit_is_div", unit_is_div, is_div);

    for (int n = 1; n <= delay; n++) begin
      @(posedge clock); #1;
      unit_ready     = (n == delay);
      unit_result    = (n == delay) ? res : $urandom;
      unit_exception = (n == delay) ? exc : 1'($urandom);
      @(negedge clock);
      check("busy_stall", stall, 1); check("busy_start", unit_start, 0);
      check("busy_wb_en", wb_en, 0);
    end

    // WB: md_valid here belongs to the retiring instruction and must not relaunch.
    @(posedge clock); #1;
    unit_ready = 1'b0; unit_exception = 1'b0; unit_result = $urandom;
    md_valid = valid_in_wb;
    @(negedge clock);
    e_en = 1'b1; e_reg = 5'd0; e_data = 32'd0;
    if (exc) begin
      e_reg = 5'd30; e_data = is_div ? 32'd5 : 32'd4;
    end else if (rd != 0) begin
      e_reg = rd; e_data = res;
    end else begin
      e_en = 1'b0;
    end
    check("wb_en", wb_en, e_en); check("wb_stall", stall, 0); check("wb_start", unit_start, 0);
    if (e_en) begin
      check("wb_reg", wb_reg, e_reg); check("wb_data", wb_data, e_data);
      exp_rf[e_reg] = e_data;
    end
    $display("op div=%0d rd=%0d a=%h b=%h exc=%0d delay=%0d -> wb_en=%0d reg=%0d data=%h",
             is_div, rd, a, b, exc, delay, wb_en, wb_reg, wb_data);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      md_valid = 1'b0; unit_ready = 1'b0;
      @(negedge clock);
      check("idle_busy", busy, 0); check("idle_stall", stall, 0); check("idle_wb_en", wb_en, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin exp_rf[i] = 32'd0; dut_rf[i] = 32'd0; end
    reset = 1'b1; md_valid = 1'b0; md_is_div = 1'b0; md_rd = '0; md_a = '0; md_b = '0;
    unit_ready = 1'b0; unit_result = '0; unit_exception = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0); check("rst_stall", stall, 0); check("rst_start", unit_start, 0);
    check("rst_wb_en", wb_en, 0); check("rst_unit_a", unit_a, 0); check("rst_unit_b", unit_b, 0);
    check("rst_is_div", unit_is_div, 0);
    @(posedge clock); #1; reset = 1'b0;
    idle_cycles(2);

    run_op(1'b0, 5'd3, 32'd6, 32'd7, 1'b0, 34, 1'b0);          // r3 = 42
    idle_cycles(1);
    run_op(1'b1, 5'd7, 32'd100, 32'd0, 1'b1, 5, 1'b0);         // r30 = 5, r7 untouched
    run_op(1'b0, 5'd9, 32'h4000_0000, 32'd4, 1'b1, 3, 1'b0);   // r30 = 4
    run_op(1'b0, 5'd0, 32'd12, 32'd12, 1'b0, 2, 1'b0);         // rd=0 -> no write
    run_op(1'b0, 5'd11, 32'd300, 32'd5, 1'b0, 1, 1'b1);        // back-to-back pair
    run_op(1'b1, 5'd12, 32'd300, 32'd5, 1'b0, 1, 1'b0);
    run_op(1'b1, 5'd13, 32'd999, 32'd3, 1'b0, 40, 1'b0);       // ready on BUSY cycle 40

    for (int t = 0; t < 10; t++) begin
      run_op(1'($urandom), 5'($urandom_range(0, 29)), $urandom, $urandom_range(0, 20),
             ($urandom_range(0, 3) == 0), $urandom_range(1, 12), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end

    // Reset in BUSY abandons the op; a late ready afterwards must not write back.
    @(posedge clock); #1;
    md_valid = 1'b1; md_is_div = 1'b0; md_rd = 5'd20; md_a = 32'd5; md_b = 32'd5;
    @(posedge clock); #1; md_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    unit_ready = 1'b1; unit_result = 32'd25; unit_exception = 1'b0;
    @(negedge clock);
    check("rst_mid_busy", busy, 0); check("rst_mid_stall", stall, 0);
    check("rst_mid_wb_en", wb_en, 0); check("rst_mid_unit_a", unit_a, 0);
    @(posedge clock); #1; unit_ready = 1'b0;
    @(negedge clock);
    check("late_ready_wb_en", wb_en, 0); check("late_ready_busy", busy, 0);
    $display("op reset mid-BUSY rd=20 -> abandoned, wb_en=%0d", wb_en);
    idle_cycles(2);

    // Unit never answers.
    @(posedge clock); #1;
    md_valid = 1'b1; md_is_div = 1'b1; md_rd = 5'd21; md_a = 32'd8; md_b = 32'd2;
    @(posedge clock); #1; md_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      @(negedge clock);
      check("wd_busy_stall", stall, 1); check("wd_busy_wb_en", wb_en, 0);
    end
    @(posedge clock); #1;
    @(negedge clock);
`ifdef MULTDIV_WATCHDOG_EN
    check("wd_wb_en", wb_en, 1); check("wd_wb_reg", wb_reg, 30);
    check("wd_wb_data", wb_data, 6); check("wd_stall", stall, 0);
    exp_rf[30] = 32'd6;
`else
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      check("nowd_stall", stall, 1); check("nowd_wb_en", wb_en, 0);
    end
`endif
    $display("op never-ready div rd=21 -> wb_en=%0d reg=%0d data=%h stall=%0d",
             wb_en, wb_reg, wb_data, stall);
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    idle_cycles(2);

    for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), dut_rf[i], exp_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
